hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Parametrised scoreboard hazard controller for the pipelined core. It tracks in-flight register writers behind decode and selects forwarding sources for ra/rb/rt. It raises a decode stall on load-use hazards and inserts bubbles, which the current fixed forward path cannot do. It sits between controller/regfile and the regwalls, and replaces the combinational forward block.

Parameters:
DATA_W, 32, datapath width
ADDR_W, 5, register address width
DEPTH, 3, tracked stages after decode (0=EX, 1=MEM, 2=WB)
LOAD_STAGE, 1, first stage index whose stage_data holds valid load data (1..DEPTH-1)
CNT_W, 16, perf counter width (used only with HAZARD_PERF_EN)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
id_valid  in  1  decode slot holds a real instruction
id_flush  in  1  kill decode instruction this cycle (branch taken)
id_ra_addr / id_rb_addr / id_rt_addr  in  ADDR_W each  source addresses
id_use_ra / id_use_rb / id_use_rt  in  1 each  source actually read
id_do_reg_write  in  1  decode instruction writes a register
id_write_reg_addr  in  ADDR_W  destination
id_is_load  in  1  destination comes from memory
reg_ra_data / reg_rb_data / reg_rt_data  in  DATA_W each  regfile read data
stage_data  in  DEPTH*DATA_W  result held in each stage, slice k = stage k
f_reg_ra_data / f_reg_rb_data / f_reg_rt_data  out  DATA_W each  forwarded operands
fwd_sel_ra / fwd_sel_rb / fwd_sel_rt  out  $clog2(DEPTH+1) each  0=regfile, k+1=stage k
stall  out  1  hold PC and REG1, bubble into REG2
stall_count  out  CNT_W  stall cycles (perf)
flush_count  out  CNT_W  flushed issues (perf)

Behaviour:
- Scoreboard: DEPTH entries {valid, is_load, addr}. Entry k mirrors stage k.
- Each clock, entries shift k→k+1; entry DEPTH-1 retires.
- Entry 0 load: if id_valid & id_do_reg_write & !stall & !id_flush, load {1, id_is_load, id_write_reg_addr}; otherwise load a bubble (valid=0).
- Match for source s: id_use_s & entry.valid & entry.addr==id_s_addr. Youngest match (lowest k) wins.
- Entry k is ready if !is_load or k>=LOAD_STAGE.
- Youngest match ready: fwd_sel_s=k+1 and f_reg_s_data=stage_data slice k.
- No match: fwd_sel_s=0 and f_reg_s_data=reg_s_data. This includes the WB same-cycle write; no regfile write-through is assumed.
- Youngest match not ready: stall=1. Forward outputs are don't-care but driven from the regfile path.
- stall, fwd_sel and f_data are combinational from the scoreboard and ID inputs. The scoreboard is the only state; there is zero added latency.
- stall is gated by id_valid & !id_flush. A flushed or invalid instruction never stalls.
- id_flush with stall: flush wins, stall=0, bubble enters entry 0.
- Load-use with LOAD_STAGE=1: exactly one stall cycle, then forward from stage 1. With LOAD_STAGE=L: L stall cycles.
- Address 0 is an ordinary register; it is tracked like any other.
- Reset (async, any time): all entries valid=0, stall=0, fwd_sel=0, counters=0. Forward data follows the regfile inputs. Reset mid-stall releases stall immediately.

Optional Feature:
HAZARD_PERF_EN
- Defined: stall_count increments each cycle stall=1; flush_count increments each cycle id_flush & id_valid. Both saturate at all-ones and clear only on reset.
- Undefined: no counter flops; both outputs are tied to 0.

Decomposition:
- Package hazard_pkg: scoreboard entry struct {valid, is_load, addr}, the FWD_REGFILE=0 constant, and the fwd_sel width function.
- One sub-module, hazard_fwd_mux: combinational per-operand youngest-match priority select plus data mux. It is instantiated three times (ra, rb, rt) and returns fwd_sel, data and not_ready.

Test Plan:
1. Back-to-back ALU ops (r3←r1+r2; r4←r3+r3) → cycle 2: fwd_sel_ra=fwd_sel_rb=1, f_reg_ra_data=stage_data[0]=result, stall=0.
2. Load r5 then ALU using r5 (LOAD_STAGE=1) → stall=1 for exactly one cycle with a bubble in entry 0; next cycle fwd_sel=2, data=stage_data[1].
3. r6 written by stage 0 and stage 2 simultaneously → youngest wins: fwd_sel=1, data=stage_data[0].
4. Load-use hazard with id_flush=1 in the same cycle → stall=0, entry 0 bubble; with HAZARD_PERF_EN, flush_count 0→1 and stall_count unchanged.
5. Assert reset during a stall cycle → stall=0 and fwd_sel=0 immediately (asynchronous); all entries invalid, and a following dependent op reads the regfile (fwd_sel=0).
6. DEPTH=4, LOAD_STAGE=2 with load then dependent op → two stall cycles, then fwd_sel=3; stall_count saturates at 0xFFFF under a long forced stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: scoreboard entry layout, the
// regfile forward-select code and the forward-select width helper.
package hazard_pkg;

    // Scoreboard addresses are stored zero-extended to this width; ADDR_W must not exceed it.
    localparam int SB_ADDR_W   = 16;
    localparam int FWD_REGFILE = 0;

    typedef struct packed {
        logic                 valid;
        logic                 is_load;
        logic [SB_ADDR_W-1:0] addr;
    } sb_entry_t;

    function automatic int fwd_sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side bundle of the hazard controller: ID-stage operands and
// destination, regfile and stage results in, forwarded operands/stall out.
interface hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = 16
);
    localparam int SEL_W = fwd_sel_w(DEPTH);

    logic                    id_valid;
    logic                    id_flush;
    logic [ADDR_W-1:0]       id_ra_addr;
    logic [ADDR_W-1:0]       id_rb_addr;
    logic [ADDR_W-1:0]       id_rt_addr;
    logic                    id_use_ra;
    logic                    id_use_rb;
    logic                    id_use_rt;
    logic                    id_do_reg_write;
    logic [ADDR_W-1:0]       id_write_reg_addr;
    logic                    id_is_load;
    logic [DATA_W-1:0]       reg_ra_data;
    logic [DATA_W-1:0]       reg_rb_data;
    logic [DATA_W-1:0]       reg_rt_data;
    logic [DEPTH*DATA_W-1:0] stage_data;

    logic [DATA_W-1:0]       f_reg_ra_data;
    logic [DATA_W-1:0]       f_reg_rb_data;
    logic [DATA_W-1:0]       f_reg_rt_data;
    logic [SEL_W-1:0]        fwd_sel_ra;
    logic [SEL_W-1:0]        fwd_sel_rb;
    logic [SEL_W-1:0]        fwd_sel_rt;
    logic                    stall;
    logic [CNT_W-1:0]        stall_count;
    logic [CNT_W-1:0]        flush_count;

    modport master (
        output id_valid, id_flush, id_ra_addr, id_rb_addr, id_rt_addr,
               id_use_ra, id_use_rb, id_use_rt, id_do_reg_write,
               id_write_reg_addr, id_is_load, reg_ra_data, reg_rb_data,
               reg_rt_data, stage_data,
        input  f_reg_ra_data, f_reg_rb_data, f_reg_rt_data,
               fwd_sel_ra, fwd_sel_rb, fwd_sel_rt, stall,
               stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_flush, id_ra_addr, id_rb_addr, id_rt_addr,
               id_use_ra, id_use_rb, id_use_rt, id_do_reg_write,
               id_write_reg_addr, id_is_load, reg_ra_data, reg_rb_data,
               reg_rt_data, stage_data,
        output f_reg_ra_data, f_reg_rb_data, f_reg_rt_data,
               fwd_sel_ra, fwd_sel_rb, fwd_sel_rt, stall,
               stall_count, flush_count
    );

endinterface

// File: rtl/hazard_fwd_mux.sv
// Per-operand forward select: youngest valid scoreboard match wins; a match
// whose data is not yet available reports not_ready and falls back to the regfile.
module hazard_fwd_mux
    import hazard_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int SEL_W      = 2
) (
    input  sb_entry_t               sb_i [DEPTH],
    input  logic                    use_i,
    input  logic [ADDR_W-1:0]       addr_i,
    input  logic [DATA_W-1:0]       reg_data_i,
    input  logic [DEPTH*DATA_W-1:0] stage_data_i,
    output logic [SEL_W-1:0]        sel_o,
    output logic [DATA_W-1:0]       data_o,
    output logic                    not_ready_o
);

    logic [SB_ADDR_W-1:0] addr_ext;
    logic [DEPTH-1:0]     match;
    logic [DEPTH-1:0]     ready;
    logic [DATA_W-1:0]    stage_arr [DEPTH];
    logic                 found;

    assign addr_ext = SB_ADDR_W'(addr_i);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        localparam bit LATE = (gi >= LOAD_STAGE);
        assign match[gi]     = use_i && sb_i[gi].valid && (sb_i[gi].addr == addr_ext);
        assign ready[gi]     = !sb_i[gi].is_load || LATE;
        assign stage_arr[gi] = stage_data_i[gi*DATA_W +: DATA_W];
    end

    always_comb begin
        sel_o       = SEL_W'(FWD_REGFILE);
        data_o      = reg_data_i;
        not_ready_o = 1'b0;
        found       = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!found && match[k]) begin
                found = 1'b1;
                if (ready[k]) begin
                    sel_o  = SEL_W'(k + 1);
                    data_o = stage_arr[k];
                end else begin
                    not_ready_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Scoreboard hazard controller: tracks in-flight writers behind decode, picks
// forward sources for ra/rb/rt and stalls decode on load-use hazards.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int CNT_W      = 16
) (
    input  logic         clock,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);

    localparam int SEL_W   = fwd_sel_w(DEPTH);
    localparam int NUM_SRC = 3;

    sb_entry_t          sb_q [DEPTH];
    sb_entry_t          sb_d [DEPTH];
    logic [ADDR_W-1:0]  src_addr      [NUM_SRC];
    logic               src_use       [NUM_SRC];
    logic [DATA_W-1:0]  src_reg_data  [NUM_SRC];
    logic [DATA_W-1:0]  src_fwd_data  [NUM_SRC];
    logic [SEL_W-1:0]   src_sel       [NUM_SRC];
    logic [NUM_SRC-1:0] src_not_ready;
    logic               stall_w;
    logic               issue_w;

    assign src_addr[0]     = bus.id_ra_addr;
    assign src_addr[1]     = bus.id_rb_addr;
    assign src_addr[2]     = bus.id_rt_addr;
    assign src_use[0]      = bus.id_use_ra;
    assign src_use[1]      = bus.id_use_rb;
    assign src_use[2]      = bus.id_use_rt;
    assign src_reg_data[0] = bus.reg_ra_data;
    assign src_reg_data[1] = bus.reg_rb_data;
    assign src_reg_data[2] = bus.reg_rt_data;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        hazard_fwd_mux #(
            .DATA_W     (DATA_W),
            .ADDR_W     (ADDR_W),
            .DEPTH      (DEPTH),
            .LOAD_STAGE (LOAD_STAGE),
            .SEL_W      (SEL_W)
        ) u_mux (
            .sb_i         (sb_q),
            .use_i        (src_use[gi]),
            .addr_i       (src_addr[gi]),
            .reg_data_i   (src_reg_data[gi]),
            .stage_data_i (bus.stage_data),
            .sel_o        (src_sel[gi]),
            .data_o       (src_fwd_data[gi]),
            .not_ready_o  (src_not_ready[gi])
        );
    end

    assign bus.fwd_sel_ra    = src_sel[0];
    assign bus.fwd_sel_rb    = src_sel[1];
    assign bus.fwd_sel_rt    = src_sel[2];
    assign bus.f_reg_ra_data = src_fwd_data[0];
    assign bus.f_reg_rb_data = src_fwd_data[1];
    assign bus.f_reg_rt_data = src_fwd_data[2];

    // A flushed or empty decode slot must never hold the front end.
    assign stall_w   = bus.id_valid && !bus.id_flush && (|src_not_ready);
    assign issue_w   = bus.id_valid && bus.id_do_reg_write && !stall_w && !bus.id_flush;
    assign bus.stall = stall_w;

    always_comb begin
        for (int k = DEPTH - 1; k > 0; k--) begin
            sb_d[k] = sb_q[k-1];
        end
        sb_d[0] = '0;
        if (issue_w) begin
            sb_d[0].valid   = 1'b1;
            sb_d[0].is_load = bus.id_is_load;
            sb_d[0].addr    = SB_ADDR_W'(bus.id_write_reg_addr);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_q[k] <= '0;
            end
        end else begin
            sb_q <= sb_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_w && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (bus.id_flush && bus.id_valid && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_count = stall_cnt_q;
    assign bus.flush_count = flush_cnt_q;
`else
    assign bus.stall_count = '0;
    assign bus.flush_count = '0;
`endif

endmodule
